// File: rtl/blit_pkg.sv
// Shared types and defaults for the blitter pixel write back end.
package blit_pkg;
    localparam int BLIT_ADDR_W = 26;
    localparam int BLIT_PIX_W  = 8;

    typedef logic signed [15:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } blit_state_e;
endpackage

// File: rtl/blit_addr_calc.sv
// Linear pixel address: base + sext(y)*zext(stride) + sext(x), wrapping at ADDR_W.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
module blit_addr_calc
    import blit_pkg::*;
#(
    parameter int ADDR_W = BLIT_ADDR_W
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [15:0]       x_i,
    input  logic [15:0]       y_i,
    input  logic [15:0]       stride_i,
    output logic [ADDR_W-1:0] addr_o
);
    localparam int EXT = ADDR_W - 16;

    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] stride_ext;

    assign x_ext      = {{EXT{x_i[15]}}, x_i};
    assign y_ext      = {{EXT{y_i[15]}}, y_i};
    assign stride_ext = {{EXT{1'b0}}, stride_i};

    // Two's-complement products truncated to ADDR_W give the correct modular result.
    assign addr_o = base_i + y_ext * stride_ext + x_ext;
endmodule

// File: rtl/blit_pixel_write.sv
// Clips each walker pixel, reads the source (or uses fill), applies colour key, writes dest.
// Latency: fill 2 cycles/pixel, copy 3 cycles/pixel with zero-wait memory.
// Backpressure: stall is high whenever a pixel is in flight; req/ack memory handshakes.
module blit_pixel_write
    import blit_pkg::*;
#(
    parameter int ADDR_W = BLIT_ADDR_W,
    parameter int PIX_W  = BLIT_PIX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       p2_rect_dest_x,
    input  logic [15:0]       p2_rect_dest_y,
    input  logic [15:0]       p2_rect_src_x,
    input  logic [15:0]       p2_rect_src_y,
    input  logic              p2_write_enable,
    input  logic [ADDR_W-1:0] dest_base,
    input  logic [15:0]       dest_stride,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [15:0]       src_stride,
    input  logic [15:0]       clip_x1,
    input  logic [15:0]       clip_y1,
    input  logic [15:0]       clip_x2,
    input  logic [15:0]       clip_y2,
    input  logic              fill_en,
    input  logic [PIX_W-1:0]  fill_colour,
    input  logic              transparent_en,
    input  logic [PIX_W-1:0]  transparent_colour,
    output logic              stall,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [PIX_W-1:0]  mem_wr_data,
    input  logic              mem_wr_ack,
    output logic [31:0]       pixel_count,
    input  logic              count_clear
);
    blit_state_e       state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic [PIX_W-1:0]  key_q, key_d;
    logic              trans_q, trans_d;
    logic [31:0]       count_q, count_d;

    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dest_addr;
    coord_t            dx, dy, cx1, cy1, cx2, cy2;
    logic              in_clip;

    blit_addr_calc #(.ADDR_W(ADDR_W)) u_src_addr (
        .base_i   (src_base),
        .x_i      (p2_rect_src_x),
        .y_i      (p2_rect_src_y),
        .stride_i (src_stride),
        .addr_o   (src_addr)
    );

    blit_addr_calc #(.ADDR_W(ADDR_W)) u_dest_addr (
        .base_i   (dest_base),
        .x_i      (p2_rect_dest_x),
        .y_i      (p2_rect_dest_y),
        .stride_i (dest_stride),
        .addr_o   (dest_addr)
    );

    assign dx  = p2_rect_dest_x;
    assign dy  = p2_rect_dest_y;
    assign cx1 = clip_x1;
    assign cy1 = clip_y1;
    assign cx2 = clip_x2;
    assign cy2 = clip_y2;

    // Half-open window; an empty window (x2<=x1 or y2<=y1) rejects everything naturally.
    assign in_clip = (dx >= cx1) && (dx < cx2) && (dy >= cy1) && (dy < cy2);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        key_d     = key_q;
        trans_d   = trans_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (p2_write_enable && in_clip) begin
                    rd_addr_d = src_addr;
                    wr_addr_d = dest_addr;
                    trans_d   = transparent_en;
                    key_d     = transparent_colour;
                    if (fill_en) begin
                        wr_data_d = fill_colour;
                        state_d   = WRITE;
                    end else begin
                        state_d   = READ;
                    end
                end
            end
            READ: begin
                if (mem_rd_ack) begin
                    if (trans_q && (mem_rd_data == key_q)) begin
                        state_d = IDLE;
                    end else begin
                        wr_data_d = mem_rd_data;
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                if (mem_wr_ack) begin
                    count_d = count_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (count_clear) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            key_q     <= '0;
            trans_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            key_q     <= key_d;
            trans_q   <= trans_d;
            count_q   <= count_d;
        end
    end

    assign stall       = (state_q != IDLE);
    assign mem_rd_req  = (state_q == READ);
    assign mem_wr_req  = (state_q == WRITE);
    assign mem_rd_addr = rd_addr_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign pixel_count = count_q;
endmodule
